riscv_muldiv: RTL



---
 rtl/riscv_muldiv_pkg.sv | 44 ++++
 rtl/riscv_muldiv.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv_pkg.sv
// Shared types and predicates for the RV32M iterative mul/div unit.
// Opcode enum (funct3), FSM states, operand-sign helpers.
package riscv_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_t;

  function automatic logic is_div(
    input muldiv_op_t op
  );
    return op[2];
  endfunction

  function automatic logic is_signed_a(
    input muldiv_op_t op
  );
    return op == OP_MUL || op == OP_MULH ||
           op == OP_MULHSU || op == OP_DIV ||
           op == OP_REM;
  endfunction

  function automatic logic is_signed_b(
    input muldiv_op_t op
  );
    return op == OP_MUL || op == OP_MULH ||
           op == OP_DIV || op == OP_REM;
  endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide, one result bit per cycle.
// Ports: CLK, RSTa, Start, op, A, B in; Res, Busy, Done out.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic             Start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Res,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  muldiv_state_t    r_state, w_next;
  muldiv_op_t       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_sa, r_sb;
  logic [WIDTH-1:0] r_b, r_res;
  // mul: [2W-1:0] product, low half holds multiplier
  // div: [2W:W] partial rem, [W-1:0] dividend->quotient
  logic [2*WIDTH:0] r_acc;

  muldiv_op_t       w_op;
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_amag, w_bmag;
  logic             w_bzero, w_ovf, w_special;
  logic [WIDTH-1:0] w_spec_res;
  logic [WIDTH:0]   w_madd;
  logic [2*WIDTH:0] w_mul_nxt, w_div_nxt;
  logic [WIDTH+1:0] w_shl;
  logic             w_qbit;
  logic [WIDTH:0]   w_rnew;
  logic [2*WIDTH-1:0] w_prodn;
  logic [WIDTH-1:0] w_fix_res;

  assign w_op   = muldiv_op_t'(op);
  assign w_sa   = is_signed_a(w_op) & A[WIDTH-1];
  assign w_sb   = is_signed_b(w_op) & B[WIDTH-1];
  assign w_amag = w_sa ? -A : A;
  assign w_bmag = w_sb ? -B : B;

  assign w_bzero = (B == '0);
  assign w_ovf   = (w_op == OP_DIV || w_op == OP_REM)
                 && A == MINV && B == '1;
  assign w_special = is_div(w_op) & (w_bzero | w_ovf);

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_spec_res = '0;
    if (w_bzero)
      w_spec_res = op[1] ? A : '1;
    else
      w_spec_res = op[1] ? '0 : A;
  end

  assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {1'b0, w_madd, r_acc[WIDTH-1:1]};

  assign w_shl  = r_acc[2*WIDTH:WIDTH-1];
  assign w_qbit = (w_shl >= {2'b0, r_b});
  assign w_rnew = w_qbit ? w_shl[WIDTH:0] - {1'b0, r_b}
                         : w_shl[WIDTH:0];
  assign w_div_nxt = {w_rnew, r_acc[WIDTH-2:0], w_qbit};

  assign w_prodn = (r_sa ^ r_sb) ? -r_acc[2*WIDTH-1:0]
                                 : r_acc[2*WIDTH-1:0];

  always_comb begin
    w_fix_res = '0;
    unique case (r_op)
      OP_MUL:
        w_fix_res = w_prodn[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:
        w_fix_res = w_prodn[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:
        w_fix_res = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0]
                                  : r_acc[WIDTH-1:0];
      OP_REM, OP_REMU:
        w_fix_res = r_sa ? -r_acc[2*WIDTH-1:WIDTH]
                         : r_acc[2*WIDTH-1:WIDTH];
      default: w_fix_res = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (Start) w_next = w_special ? S_DONE : S_CALC;
      S_CALC:
        if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      r_op  <= OP_MUL;
      r_cnt <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_b   <= '0;
      r_res <= '0;
      r_acc <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (Start) begin
            r_op  <= w_op;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_b   <= w_bmag;
            r_cnt <= '0;
            r_acc <= {{(WIDTH+1){1'b0}}, w_amag};
            if (w_special) r_res <= w_spec_res;
          end
        S_CALC: begin
          r_acc <= is_div(r_op) ? w_div_nxt : w_mul_nxt;
          r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
        S_FIX:   r_res <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign Res  = r_res;
  assign Busy = (r_state == S_CALC) || (r_state == S_FIX);
  assign Done = (r_state == S_DONE);

endmodule
